// File: rtl/spm_seq_ctrl_if.sv
// rtl/spm_seq_ctrl_if.sv - operand/product handshake bundle for the SPM sequencer
interface spm_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/spm_seq_ctrl.sv
// rtl/spm_seq_ctrl.sv - sequencing controller for the signed serial-parallel multiplier
module spm_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  spm_seq_ctrl_if.slave    io,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] spm_y,
  output logic             spm_clear,
  output logic             spm_en,
  output logic             spm_x_bit,
  input  logic             spm_p_bit
);

  localparam int CNT_W = $clog2(2*WIDTH + DP_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*WIDTH + DP_LAT - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(DP_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 clear_q;
  logic                 en_q;
  logic                 x_bit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clear_q     <= 1'b0;
      en_q        <= 1'b0;
      x_bit_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            mcand_q   <= io.mcand;
            mplier_q  <= io.mplier;
            product_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            clear_q   <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          clear_q <= 1'b0;
          cnt_q   <= '0;
          if (abort) begin
            busy_q    <= 1'b0;
            product_q <= '0;
            state_q   <= IDLE;
          end else begin
            en_q    <= 1'b1;
            x_bit_q <= mplier_q[0];
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            en_q      <= 1'b0;
            x_bit_q   <= 1'b0;
            busy_q    <= 1'b0;
            product_q <= '0;
            state_q   <= IDLE;
          end else begin
            if (cnt_q >= CAP_FIRST) begin
              product_q <= {spm_p_bit, product_q[2*WIDTH-1:1]};
            end
            // Arithmetic shift keeps feeding the sign bit once the multiplier is exhausted
            mplier_q <= {mplier_q[WIDTH-1], mplier_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
              en_q        <= 1'b0;
              x_bit_q     <= 1'b0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              x_bit_q <= mplier_q[1];
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it reads low while reset is held
  assign io.in_ready  = rst && (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.product   = product_q;
  assign busy         = busy_q;
  assign spm_y        = mcand_q;
  assign spm_clear    = clear_q;
  assign spm_en       = en_q;
  assign spm_x_bit    = x_bit_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// tb/tb_spm_seq_ctrl.sv - directed scoreboard bench for spm_seq_ctrl with a serial datapath model
module tb_spm_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        abort;
  logic        busy;
  logic [31:0] spm_y;
  logic        spm_clear;
  logic        spm_en;
  logic        spm_x_bit;
  logic        spm_p_bit;

  int tests;
  int fails;
  logic [63:0] exp_q[$];

  spm_seq_ctrl_if #(.WIDTH(32)) bus ();

  spm_seq_ctrl #(.WIDTH(32), .DP_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus.slave),
    .abort     (abort),
    .busy      (busy),
    .spm_y     (spm_y),
    .spm_clear (spm_clear),
    .spm_en    (spm_en),
    .spm_x_bit (spm_x_bit),
    .spm_p_bit (spm_p_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial datapath: accumulate x_k * y * 2^k, emit product bit k one cycle later
  logic [63:0] acc;
  logic [63:0] nacc;
  logic [63:0] ysx;
  int          k;

  assign ysx = {{32{spm_y[31]}}, spm_y};

  always_comb begin
    nacc = acc;
    if (spm_x_bit && k < 64) nacc = acc + (ysx << k);
  end

  always @(posedge clk) begin
    if (spm_clear) begin
      acc       <= '0;
      k         <= 0;
      spm_p_bit <= 1'b0;
    end else if (spm_en) begin
      acc       <= nacc;
      spm_p_bit <= (k < 64) ? nacc[k] : 1'b0;
      k         <= k + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input int hold, input logic with_abort);
    int n;
    logic [63:0] keep;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.mcand     = a;
    bus.mplier    = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    abort         = with_abort;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    bus.in_valid = 1'b0;
    abort        = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("in_ready_while_busy", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) check("spm_y_in_shift", 64'(spm_y), 64'(a));
    end
    check("latency", 64'(n), 64'd66);
    if (hold > 0) begin
      keep         = bus.product;
      bus.in_valid = 1'b1;
      bus.mcand    = 32'h1234_5678;
      bus.mplier   = 32'h0000_0011;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_product_stable", bus.product, keep);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      check("product", bus.product, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    check("out_valid_after_handshake", 64'(bus.out_valid), 64'd0);
    check("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
    check("no_accept_in_done", 64'(busy), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int seen_ov;
    tests         = 0;
    fails         = 0;
    rst           = 1'b0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mcand     = '0;
    bus.mplier    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", bus.product, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0);
    run_op(-32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 0, 1'b0);
    run_op(32'd6, -32'sd7, 64'hFFFF_FFFF_FFFF_FFD6, 0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 10, 1'b0);

    // Abort at cnt=20
    bus.mcand    = 32'd9;
    bus.mplier   = 32'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_spm_en", 64'(spm_en), 64'd0);
    check("abort_product", bus.product, 64'd0);
    seen_ov = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_ov++;
    end
    check("abort_no_out_valid", 64'(seen_ov), 64'd0);
    run_op(32'd2, 32'd3, 64'd6, 0, 1'b1);

    // Asynchronous reset at cnt=40
    bus.mcand    = 32'd12345;
    bus.mplier   = 32'd678;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (41) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_spm_en", 64'(spm_en), 64'd0);
    check("mid_rst_spm_clear", 64'(spm_clear), 64'd0);
    check("mid_rst_spm_x_bit", 64'(spm_x_bit), 64'd0);
    check("mid_rst_spm_y", 64'(spm_y), 64'd0);
    check("mid_rst_product", bus.product, 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd1, 32'd1, 64'd1, 0, 1'b0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
